bp_be_stride_detector: RTL and testbench
========================================

// Module: bp_be_stride_detector
// PURPOSE
//  Trains on committed load (pc, vaddr) pairs in a small direct-mapped table and finds loads with a constant stride.
//  Drives the discovery handshake of bp_be_loop_inference:
//  - start_discovery_o when a striding load first appears
//  - confirm_discovery_o once its stride is trusted
//  Tracks one candidate at a time, locked until the consumer signals completion.
// PARAMETERS
//  bp_params_p       e_bp_default_cfg  processor config; supplies vaddr_width_p
//  els_p             8                 table entries, power of 2
//  stride_width_p    16                signed stride width stored per entry
//  conf_width_p      2                 saturating confidence counter width
//  start_thresh_p    1                 confidence at which start_discovery_o fires
//  confirm_thresh_p  3                 confidence at which confirm_discovery_o fires; > start_thresh_p
// PORTS
//  clk_i                in   1               clock
//  reset_i              in   1               synchronous, active-high reset
//  load_v_i             in   1               committed load valid this cycle
//  load_pc_i            in   vaddr_width_p   load PC
//  load_vaddr_i         in   vaddr_width_p   load effective virtual address
//  start_discovery_o    out  1               1-cycle pulse: new candidate, see striding_pc_o
//  confirm_discovery_o  out  1               1-cycle pulse: candidate confirmed
//  striding_pc_o        out  vaddr_width_p   PC of tracked candidate, held stable outside IDLE
//  stride_o             out  stride_width_p  signed stride of tracked candidate
//  done_i               in   1               consumer finished with candidate (loop v_o & yumi)
// BEHAVIOUR
//  Interface: one clock, clk_i; reset_i is synchronous and active-high.
//  Reset: all entries invalid; FSM=IDLE; all outputs 0. A reset mid-operation abandons the candidate; no pulse follows.
//  Index and tag:
//  - index = load_pc_i[1 +: $clog2(els_p)]
//  - entry = {v, pc, last_addr, stride, conf}; hit = v & (pc == load_pc_i)
//  Update, in the cycle load_v_i=1; the entry is written at the clock edge:
//  - Miss: allocate (replace); last_addr=vaddr, stride=0, conf=0.
//  - Hit: d = load_vaddr_i - last_addr, full vaddr width.
//    - d fits signed stride_width_p, d != 0, and d == stride: conf++, saturating.
//    - Otherwise: stride = d if it fits, else 0; conf=0.
//    - Always: last_addr=vaddr.
//  conf_nxt is the value being written this cycle.
//  FSM; all outputs registered, so a pulse appears the cycle after the qualifying load:
//  - IDLE: a hit with conf_nxt == start_thresh_p
//    - -> DISC; latch striding_pc_o = load_pc_i and stride_o = d; pulse start_discovery_o.
//  - DISC: a hit on striding_pc_o with conf_nxt == confirm_thresh_p
//    - -> LOCK; pulse confirm_discovery_o.
//    - If instead that hit resets conf to 0: -> IDLE, silently; the consumer is restarted by the next start.
//  - LOCK: no pulses; the table keeps training. done_i -> IDLE.
//  - done_i is ignored in IDLE and DISC.
//  Simultaneous events:
//  - done_i and a qualifying load in the same cycle: go to IDLE only. No start that cycle; the next qualifying load may start.
//  - In DISC, a load from another PC reaching start_thresh_p is ignored: no preemption.
//  - In DISC, a load that evicts the tracked entry: -> IDLE.
//  Pulse rules:
//  - start_discovery_o and confirm_discovery_o are never both high.
//  - Each is high for exactly 1 cycle per transition.
//  - Confidence saturates at 2^conf_width_p-1. Subtraction wraps mod 2^vaddr_width_p before the fit check.
// TESTING
//  1. PC 0x80001000: vaddr 0x100, 0x108, 0x110, 0x118, 0x120.
//     -> start pulse after the 3rd load (conf=1), striding_pc_o=0x80001000, stride_o=8.
//     -> confirm pulse after the 5th load (conf=3).
//  2. Same PC: vaddrs 0x100, 0x108, 0x110, then 0x200.
//     -> start after the 3rd load; no confirm after the 4th (stride broken, conf reset); FSM back in IDLE.
//  3. Two PCs aliasing index 0, stepping by 8, interleaved -> continual replacement; no pulse ever.
//  4. In LOCK, assert done_i together with a qualifying load from a new PC.
//     -> IDLE, no start that cycle; the next qualifying load of the new PC pulses start.
//  5. Stride 0x10000, which overflows 16 bits -> stride stored 0, conf stays 0, no pulses.
//     Negative stride -8 (0x200, 0x1F8, 0x1F0) -> start with stride_o=0xFFF8.
//  6. Assert reset_i while in DISC -> all outputs 0 next cycle.
//     Replaying scenario 1 from its first load needs the full 3 loads to start again.

Source files
------------

// File: rtl/bp_be_stride_detector.sv
// Constant-stride load detector: trains a direct-mapped table on committed loads and
// drives the start/confirm discovery handshake for one tracked candidate at a time.
module bp_be_stride_detector #(
  parameter int vaddr_width_p    = 39,
  parameter int els_p            = 8,
  parameter int stride_width_p   = 16,
  parameter int conf_width_p     = 2,
  parameter int start_thresh_p   = 1,
  parameter int confirm_thresh_p = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_v_i,
  input  logic [vaddr_width_p-1:0]  load_pc_i,
  input  logic [vaddr_width_p-1:0]  load_vaddr_i,
  output logic                      start_discovery_o,
  output logic                      confirm_discovery_o,
  output logic [vaddr_width_p-1:0]  striding_pc_o,
  output logic [stride_width_p-1:0] stride_o,
  input  logic                      done_i
);

  // state  | meaning
  // e_idle | no candidate; waiting for a hit that reaches start_thresh_p
  // e_disc | candidate announced; waiting for confirm_thresh_p on its PC
  // e_lock | candidate confirmed; held until the consumer signals done_i
  typedef enum logic [1:0] {e_idle, e_disc, e_lock} state_e;

  localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [conf_width_p-1:0] conf_max_lp     = '1;
  localparam logic [conf_width_p-1:0] conf_start_lp   = conf_width_p'(start_thresh_p);
  localparam logic [conf_width_p-1:0] conf_confirm_lp = conf_width_p'(confirm_thresh_p);

  logic [els_p-1:0]          v_r;
  logic [vaddr_width_p-1:0]  pc_r     [els_p];
  logic [vaddr_width_p-1:0]  addr_r   [els_p];
  logic [stride_width_p-1:0] stride_r [els_p];
  logic [conf_width_p-1:0]   conf_r   [els_p];

  logic [idx_w_lp-1:0]       idx, trk_idx;
  logic                      hit, d_fits, d_match;
  logic [vaddr_width_p-1:0]  d;
  logic [stride_width_p-1:0] d_trunc, stride_nxt;
  logic [conf_width_p-1:0]   conf_nxt;

  assign idx     = load_pc_i[1 +: idx_w_lp];
  assign trk_idx = striding_pc_o[1 +: idx_w_lp];
  assign hit     = v_r[idx] & (pc_r[idx] == load_pc_i);
  assign d       = load_vaddr_i - addr_r[idx];
  assign d_trunc = d[stride_width_p-1:0];
  // d fits the stride field when every bit above the field's sign bit repeats it
  assign d_fits  = (d[vaddr_width_p-1:stride_width_p-1]
                    == {(vaddr_width_p-stride_width_p+1){d[stride_width_p-1]}});
  assign d_match = d_fits & (d != '0) & (d_trunc == stride_r[idx]);

  always_comb begin
    stride_nxt = '0;
    conf_nxt   = '0;
    if (hit) begin
      if (d_match) begin
        stride_nxt = stride_r[idx];
        conf_nxt   = (conf_r[idx] == conf_max_lp) ? conf_max_lp
                                                  : conf_r[idx] + conf_width_p'(1);
      end else begin
        stride_nxt = d_fits ? d_trunc : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) v_r <= '0;
    else if (load_v_i) v_r[idx] <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (load_v_i) begin
      pc_r[idx]     <= load_pc_i;
      addr_r[idx]   <= load_vaddr_i;
      stride_r[idx] <= stride_nxt;
      conf_r[idx]   <= conf_nxt;
    end
  end

  state_e state_r, state_n;
  logic   start_n, confirm_n, latch_n;
  logic   trk_hit, trk_evict;

  assign trk_hit   = load_v_i & hit & (load_pc_i == striding_pc_o);
  assign trk_evict = load_v_i & (idx == trk_idx) & (load_pc_i != striding_pc_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n   = state_r;
    start_n   = 1'b0;
    confirm_n = 1'b0;
    latch_n   = 1'b0;
    unique case (state_r)
      e_idle: begin
        if (load_v_i & hit & (conf_nxt == conf_start_lp)) begin
          state_n = e_disc;
          start_n = 1'b1;
          latch_n = 1'b1;
        end
      end
      e_disc: begin
        if (trk_hit) begin
          if (conf_nxt == conf_confirm_lp) begin
            state_n   = e_lock;
            confirm_n = 1'b1;
          end else if (conf_nxt == '0) begin
            state_n = e_idle;
          end
        end else if (trk_evict) begin
          state_n = e_idle;
        end
      end
      e_lock: begin
        // a qualifying load coinciding with done_i cannot start: LOCK never starts
        if (done_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      start_discovery_o   <= 1'b0;
      confirm_discovery_o <= 1'b0;
      striding_pc_o       <= '0;
      stride_o            <= '0;
    end else begin
      start_discovery_o   <= start_n;
      confirm_discovery_o <= confirm_n;
      if (latch_n) begin
        striding_pc_o <= load_pc_i;
        stride_o      <= d_trunc;
      end
    end
  end

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Randomized plus directed bench for bp_be_stride_detector against a behavioural model.
module tb_bp_be_stride_detector;
  localparam int VW = 39;
  localparam longint VMASK = (longint'(1) << VW) - 1;
  localparam longint SIGNB = longint'(1) << (VW - 1);
  localparam int ST_IDLE = 0, ST_DISC = 1, ST_LOCK = 2;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          load_v_i = 1'b0;
  logic [VW-1:0] load_pc_i = '0;
  logic [VW-1:0] load_vaddr_i = '0;
  logic          done_i = 1'b0;
  logic          start_discovery_o, confirm_discovery_o;
  logic [VW-1:0] striding_pc_o;
  logic [15:0]   stride_o;

  bp_be_stride_detector dut (
    .clk_i(clk_i), .reset_i(reset_i), .load_v_i(load_v_i),
    .load_pc_i(load_pc_i), .load_vaddr_i(load_vaddr_i),
    .start_discovery_o(start_discovery_o), .confirm_discovery_o(confirm_discovery_o),
    .striding_pc_o(striding_pc_o), .stride_o(stride_o), .done_i(done_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // reference model: table of entries holding plain integers, stride kept as signed value
  typedef struct { bit v; longint pc; longint last; longint stride; int conf; } ent_t;
  ent_t   tbl [8];
  int     m_state;
  longint m_pc, m_stride;
  bit     m_start, m_confirm;

  task automatic model_step(input bit lv, input longint pc, input longint va,
                            input bit dn, input bit rs);
    int     i;
    bit     hit, fits;
    longint d, sd, new_stride;
    int     new_conf;
    m_start   = 0;
    m_confirm = 0;
    if (rs) begin
      foreach (tbl[k]) tbl[k].v = 0;
      m_state = ST_IDLE; m_pc = 0; m_stride = 0;
      return;
    end
    if (!lv) begin
      if (m_state == ST_LOCK && dn) m_state = ST_IDLE;
      return;
    end
    i    = int'((pc >> 1) & 7);
    hit  = tbl[i].v && tbl[i].pc == pc;
    d    = (va - tbl[i].last) & VMASK;
    sd   = (d >= SIGNB) ? d - (longint'(1) << VW) : d;
    fits = (sd >= -32768) && (sd <= 32767);
    new_stride = 0;
    new_conf   = 0;
    if (hit) begin
      if (fits && sd != 0 && sd == tbl[i].stride) begin
        new_stride = tbl[i].stride;
        new_conf   = (tbl[i].conf >= 3) ? 3 : tbl[i].conf + 1;
      end else begin
        new_stride = fits ? sd : 0;
      end
    end
    case (m_state)
      ST_IDLE: if (hit && new_conf == 1) begin
        m_state = ST_DISC; m_start = 1; m_pc = pc; m_stride = sd;
      end
      ST_DISC: begin
        if (pc == m_pc && hit) begin
          if (new_conf == 3) begin m_state = ST_LOCK; m_confirm = 1; end
          else if (new_conf == 0) m_state = ST_IDLE;
        end else if (pc != m_pc && i == int'((m_pc >> 1) & 7)) begin
          m_state = ST_IDLE;
        end
      end
      default: if (dn) m_state = ST_IDLE;
    endcase
    tbl[i].v = 1; tbl[i].pc = pc; tbl[i].last = va;
    tbl[i].stride = new_stride; tbl[i].conf = new_conf;
  endtask

  task automatic cycle(input bit lv, input longint pc, input longint va,
                       input bit dn, input bit rs);
    load_v_i     = lv;
    load_pc_i    = pc[VW-1:0];
    load_vaddr_i = va[VW-1:0];
    done_i       = dn;
    reset_i      = rs;
    @(posedge clk_i);
    model_step(lv, pc & VMASK, va & VMASK, dn, rs);
    #1;
    cyc++;
    check("start", longint'(start_discovery_o), longint'(m_start));
    check("confirm", longint'(confirm_discovery_o), longint'(m_confirm));
    check("striding_pc", longint'(striding_pc_o), m_pc);
    check("stride", longint'(stride_o), m_stride & 'hFFFF);
    check("pulse_excl", longint'(start_discovery_o & confirm_discovery_o), 0);
  endtask

  task automatic ld(input longint pc, input longint va);
    cycle(1, pc, va, 0, 0);
  endtask

  task automatic rst();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
  endtask

  localparam longint PA = 'h80001000;
  localparam longint PB = 'h80001010;
  localparam longint PC = 'h80002004;

  longint pool_pc  [6] = '{'h80001000, 'h80001010, 'h80002004, 'h8000300a, 'h80004006, 'h80005004};
  longint strides  [6] = '{8, -8, 4, 'h10000, 16, 0};
  longint cur_va   [6];
  longint cur_st   [6];

  initial begin
    rst();
    check("reset_start", longint'(start_discovery_o), 0);
    check("reset_pc", longint'(striding_pc_o), 0);

    // 1: steady stride 8
    ld(PA, 'h100); ld(PA, 'h108); ld(PA, 'h110);
    check("s1_start", longint'(start_discovery_o), 1);
    check("s1_pc", longint'(striding_pc_o), PA);
    check("s1_stride", longint'(stride_o), 8);
    ld(PA, 'h118);
    check("s1_no_confirm_yet", longint'(confirm_discovery_o), 0);
    ld(PA, 'h120);
    check("s1_confirm", longint'(confirm_discovery_o), 1);

    // 2: stride broken in DISC returns silently to IDLE
    rst();
    ld(PA, 'h100); ld(PA, 'h108); ld(PA, 'h110);
    check("s2_start", longint'(start_discovery_o), 1);
    ld(PA, 'h200);
    check("s2_no_confirm", longint'(confirm_discovery_o), 0);
    ld(PA, 'h208); ld(PA, 'h210);
    check("s2_restart", longint'(start_discovery_o), 1);

    // 3: aliasing PCs keep replacing each other
    rst();
    for (int k = 0; k < 6; k++) begin
      ld(PA, 'h100 + 8 * k);
      check("s3_quiet", longint'(start_discovery_o | confirm_discovery_o), 0);
      ld(PB, 'h900 + 8 * k);
      check("s3_quiet", longint'(start_discovery_o | confirm_discovery_o), 0);
    end

    // 4: done_i coincides with a qualifying load from another PC
    rst();
    ld(PA, 'h100); ld(PA, 'h108); ld(PA, 'h110); ld(PA, 'h118); ld(PA, 'h120);
    ld(PC, 'h300); ld(PC, 'h304);
    cycle(1, PC, 'h308, 1, 0);
    check("s4_no_start", longint'(start_discovery_o), 0);
    ld(PC, 'h400); ld(PC, 'h404); ld(PC, 'h408);
    check("s4_start", longint'(start_discovery_o), 1);
    check("s4_pc", longint'(striding_pc_o), PC);

    // 5: overflowing stride, then a negative stride
    rst();
    for (int k = 0; k < 5; k++) begin
      ld(PA, 'h10000 * k);
      check("s5_overflow_quiet", longint'(start_discovery_o), 0);
    end
    ld(PC, 'h200); ld(PC, 'h1F8); ld(PC, 'h1F0);
    check("s5_neg_start", longint'(start_discovery_o), 1);
    check("s5_neg_stride", longint'(stride_o), 'hFFF8);

    // 6: reset while in DISC, then replay
    rst();
    ld(PA, 'h100); ld(PA, 'h108); ld(PA, 'h110);
    cycle(0, 0, 0, 0, 1);
    check("s6_rst_start", longint'(start_discovery_o), 0);
    check("s6_rst_pc", longint'(striding_pc_o), 0);
    check("s6_rst_stride", longint'(stride_o), 0);
    ld(PA, 'h100); ld(PA, 'h108);
    check("s6_no_early_start", longint'(start_discovery_o), 0);
    ld(PA, 'h110);
    check("s6_restart", longint'(start_discovery_o), 1);

    // random mix of PCs, strides, breaks, done and occasional reset
    rst();
    for (int k = 0; k < 6; k++) begin
      cur_va[k] = longint'($urandom_range(0, 'hFFFF)) << 4;
      cur_st[k] = strides[$urandom_range(0, 5)];
    end
    for (int n = 0; n < 4000; n++) begin
      int  p;
      bit  lv, dn, rs;
      p  = $urandom_range(0, 5);
      lv = ($urandom_range(0, 3) != 0);
      dn = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) cur_st[p] = strides[$urandom_range(0, 5)];
      if ($urandom_range(0, 31) == 0) cur_va[p] = longint'($urandom) << 3;
      cycle(lv, pool_pc[p], cur_va[p], dn, rs);
      if (lv) cur_va[p] = (cur_va[p] + cur_st[p]) & VMASK;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
